alu_seq: RTL and testbench

Parametrised, registered successor to the combinational 16-bit ALU, extended with a valid/ready handshake on both sides and an iterative signed multiply. It sits between operand fetch and writeback in the lab datapath. Single-cycle ops and the multi-cycle multiply share one output holding register, so downstream back-pressure stalls the block cleanly.

---
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq.sv | 203 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// Handshake/operand bundle for alu_seq: upstream valid/ready with operands and
// opcode, downstream valid/ready with result, flags and the multiply-busy status.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       alu_code;
  logic             coe;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic             vout;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, A, B, alu_code, coe, out_ready,
    input  in_ready, out_valid, C, vout, cout, busy
  );

  modport slave (
    input  in_valid, A, B, alu_code, coe, out_ready,
    output in_ready, out_valid, C, vout, cout, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides and a shared output holding register.
// Define ALU_SEQ_MUL_EN to build the iterative signed multiply (opcode 00_110).
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00_000,
    OP_ADDU = 5'b00_001,
    OP_SUB  = 5'b00_010,
    OP_SUBU = 5'b00_011,
    OP_INC  = 5'b00_100,
    OP_DEC  = 5'b00_101,
    OP_MUL  = 5'b00_110,
    OP_AND  = 5'b01_000,
    OP_OR   = 5'b01_001,
    OP_XOR  = 5'b01_010,
    OP_NOT  = 5'b01_100,
    OP_SLL  = 5'b10_000,
    OP_SRL  = 5'b10_001,
    OP_SLA  = 5'b10_010,
    OP_SRA  = 5'b10_011,
    OP_SLE  = 5'b11_000,
    OP_SLT  = 5'b11_001,
    OP_SGE  = 5'b11_010,
    OP_SGT  = 5'b11_011,
    OP_SEQ  = 5'b11_100,
    OP_SNE  = 5'b11_101
  } op_e;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_c;
  logic             r_vout;
  logic             r_cout;
  logic             r_out_valid;
  logic             r_busy;

  logic             w_idle;
  logic             w_in_ready;
  logic             w_accept;

  logic [WIDTH-1:0] w_opb;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic             w_add_v;
  logic [SHW-1:0]   w_shamt;

  logic [WIDTH-1:0] w_res;
  logic             w_v;
  logic             w_c;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {IDLE, MUL} state_e;

  state_e             r_state;
  logic [WIDTH-1:0]   r_ma;
  logic [WIDTH-1:0]   r_mb;
  logic               r_mcoe;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHW-1:0]     r_cnt;

  logic [2*WIDTH-1:0] w_mext;
  logic [2*WIDTH-1:0] w_term;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH:0]     w_mul_hi;
  logic               w_mul_v;

  assign w_idle = (r_state == IDLE);

  // MSB-first Horner accumulation; bit WIDTH-1 of B carries negative weight.
  assign w_mext    = {{WIDTH{r_ma[WIDTH-1]}}, r_ma};
  assign w_term    = !r_mb[r_cnt]                   ? '0 :
                     (r_cnt == SHW'(WIDTH - 1))     ? -w_mext : w_mext;
  assign w_acc_nxt = {r_acc[2*WIDTH-2:0], 1'b0} + w_term;
  assign w_mul_hi  = w_acc_nxt[2*WIDTH-1:WIDTH-1];
  assign w_mul_v   = !((&w_mul_hi) || !(|w_mul_hi));
`else
  assign w_idle = 1'b1;
`endif

  assign w_in_ready = w_idle && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  // Every add/sub/inc/dec goes through one adder as A + opb + cin.
  always_comb begin
    w_opb = bus.B;
    w_cin = 1'b0;
    case (bus.alu_code)
      OP_SUB, OP_SUBU: begin
        w_opb = ~bus.B;
        w_cin = 1'b1;
      end
      OP_INC: w_opb = ONE;
      OP_DEC: begin
        w_opb = ~ONE;
        w_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_sum   = {1'b0, bus.A} + {1'b0, w_opb} + {{WIDTH{1'b0}}, w_cin};
  assign w_add_v = (bus.A[WIDTH-1] == w_opb[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != bus.A[WIDTH-1]);
  assign w_shamt = bus.B[SHW-1:0];

  always_comb begin
    w_res = '0;
    w_v   = 1'b0;
    w_c   = 1'b0;
    case (bus.alu_code)
      OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_INC, OP_DEC: begin
        w_res = w_sum[WIDTH-1:0];
        w_v   = w_add_v;
        w_c   = w_sum[WIDTH];
      end
      OP_AND:         w_res = bus.A & bus.B;
      OP_OR:          w_res = bus.A | bus.B;
      OP_XOR:         w_res = bus.A ^ bus.B;
      OP_NOT:         w_res = ~bus.A;
      OP_SLL, OP_SLA: w_res = bus.A << w_shamt;
      OP_SRL:         w_res = bus.A >> w_shamt;
      OP_SRA:         w_res = $signed(bus.A) >>> w_shamt;
      OP_SLE: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) <= $signed(bus.B))};
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) <  $signed(bus.B))};
      OP_SGE: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) >= $signed(bus.B))};
      OP_SGT: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.A) >  $signed(bus.B))};
      OP_SEQ: w_res = {{(WIDTH-1){1'b0}}, (bus.A == bus.B)};
      OP_SNE: w_res = {{(WIDTH-1){1'b0}}, (bus.A != bus.B)};
      default: ;
    endcase
    if (bus.coe) begin
      w_v = 1'b0;
      w_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c         <= '0;
      r_vout      <= 1'b0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_state     <= IDLE;
      r_ma        <= '0;
      r_mb        <= '0;
      r_mcoe      <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
`endif
    end else begin
      // A load later in this block overrides the drain clear.
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
`ifdef ALU_SEQ_MUL_EN
      if (r_state == MUL) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt - SHW'(1);
        if (r_cnt == '0) begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_c         <= w_acc_nxt[WIDTH-1:0];
          r_vout      <= w_mul_v && !r_mcoe;
          r_cout      <= 1'b0;
          r_out_valid <= 1'b1;
        end
      end else if (w_accept && (bus.alu_code == OP_MUL)) begin
        r_state <= MUL;
        r_busy  <= 1'b1;
        r_ma    <= bus.A;
        r_mb    <= bus.B;
        r_mcoe  <= bus.coe;
        r_acc   <= '0;
        r_cnt   <= SHW'(WIDTH - 1);
      end else
`endif
      if (w_accept) begin
        r_c         <= w_res;
        r_vout      <= w_v;
        r_cout      <= w_c;
        r_out_valid <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.C         = r_c;
  assign bus.vout      = r_vout;
  assign bus.cout      = r_cout;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq (WIDTH 16, plus a WIDTH 32 shift check).
module tb_alu_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  alu_seq_if #(.WIDTH(16)) bus16 ();
  alu_seq_if #(.WIDTH(32)) bus32 ();

  alu_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  alu_seq #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: returns {vout, cout, C} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [4:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic coe);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint r  = 0;
    int     sh = int'(b[3:0]);
    logic [15:0] res = '0;
    logic v = 1'b0;
    logic c = 1'b0;
    case (op)
      5'b00000, 5'b00001: begin r = sa + sb; c = (ua + ub) > 65535; end
      5'b00010, 5'b00011: begin r = sa - sb; c = (ua >= ub);        end
      5'b00100:           begin r = sa + 1;  c = (ua == 65535);     end
      5'b00101:           begin r = sa - 1;  c = (ua >= 1);         end
`ifdef ALU_SEQ_MUL_EN
      5'b00110:           begin r = sa * sb; c = 1'b0;              end
`endif
      default: ;
    endcase
    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101
`ifdef ALU_SEQ_MUL_EN
      , 5'b00110
`endif
      : begin
        res = r[15:0];
        v   = (r > 32767) || (r < -32768);
      end
      5'b01000: res = a & b;
      5'b01001: res = a | b;
      5'b01010: res = a ^ b;
      5'b01100: res = ~a;
      5'b10000, 5'b10010: res = 16'((ua * (64'd1 << sh)) & 65535);
      5'b10001: res = 16'(ua / (64'd1 << sh));
      5'b10011: begin r = sa >>> sh; res = r[15:0]; end
      5'b11000: res = {15'd0, sa <= sb};
      5'b11001: res = {15'd0, sa <  sb};
      5'b11010: res = {15'd0, sa >= sb};
      5'b11011: res = {15'd0, sa >  sb};
      5'b11100: res = {15'd0, sa == sb};
      5'b11101: res = {15'd0, sa != sb};
      default:  res = '0;
    endcase
    if (coe || !(op[4:3] == 2'b00)) begin
      v = 1'b0;
      c = 1'b0;
    end
    return {v, c, res};
  endfunction

  logic [4:0] single_ops [19] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                                   5'b00101, 5'b01000, 5'b01001, 5'b01010, 5'b01100,
                                   5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b11000,
                                   5'b11001, 5'b11010, 5'b11011, 5'b11100};

  function automatic logic [15:0] rand_operand();
    logic [15:0] corners [5] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001};
    if ($urandom_range(3) == 0) return corners[$urandom_range(4)];
    return 16'($urandom);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op on the 16-bit port and waits (bounded) for its result.
  task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic coe, output logic [17:0] got, output logic ok);
    int n = 0;
    ok = 1'b1;
    got = '0;
    bus16.alu_code = op;
    bus16.A = a;
    bus16.B = b;
    bus16.coe = coe;
    bus16.in_valid = 1'b1;
    while (!bus16.in_ready && n < 50) begin step(); n++; end
    if (!bus16.in_ready) begin
      ok = 1'b0;
      bus16.in_valid = 1'b0;
      return;
    end
    step();
    bus16.in_valid = 1'b0;
    n = 0;
    while (!bus16.out_valid && n < 50) begin step(); n++; end
    if (!bus16.out_valid) ok = 1'b0;
    got = {bus16.vout, bus16.cout, bus16.C};
  endtask

  task automatic test_reset();
    logic [17:0] got;
    logic ok;
    rst_n = 1'b0;
    step();
    step();
    vectors++;
    if (bus16.out_valid !== 1'b0 || bus16.C !== 16'h0 || bus16.busy !== 1'b0 ||
        bus16.in_ready !== 1'b1 || bus16.vout !== 1'b0 || bus16.cout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ov=%b C=%h busy=%b rdy=%b v=%b c=%b, required ov=0 C=0000 busy=0 rdy=1 v=0 c=0",
               bus16.out_valid, bus16.C, bus16.busy, bus16.in_ready, bus16.vout, bus16.cout);
    end
    rst_n = 1'b1;
    step();
    bus16.alu_code = 5'b00000;
    bus16.A = 16'h0003;
    bus16.B = 16'h0004;
    bus16.coe = 1'b0;
    bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    vectors++;
    if (bus16.out_valid !== 1'b1 || bus16.C !== 16'h0007) begin
      miscompares++;
      $display("FAIL reset_first_add: ov=%b C=%h, required ov=1 C=0007", bus16.out_valid, bus16.C);
    end
    step();
    run_op(5'b00000, 16'h0001, 16'h0001, 1'b0, got, ok);
  endtask

  task automatic test_flags();
    logic [17:0] got;
    logic ok;
    logic [4:0]  ops  [5] = '{5'b00000, 5'b00000, 5'b00011, 5'b00100, 5'b00101};
    logic [15:0] as   [5] = '{16'h7FFF, 16'h7FFF, 16'h0001, 16'h7FFF, 16'h8000};
    logic [15:0] bs   [5] = '{16'h0001, 16'h0001, 16'h0002, 16'h0000, 16'h0000};
    logic        coes [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [17:0] exps [5] = '{{2'b10, 16'h8000}, {2'b00, 16'h8000}, {2'b00, 16'hFFFF},
                             {2'b10, 16'h8000}, {2'b11, 16'h7FFF}};
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], coes[i], got, ok);
      vectors++;
      if (!ok || got !== exps[i]) begin
        miscompares++;
        $display("FAIL flags[%0d]: ok=%b {v,c,C}=%b_%h, required %b_%h",
                 i, ok, got[17:16], got[15:0], exps[i][17:16], exps[i][15:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [17:0] got;
    logic [17:0] exp;
    logic ok;
    logic [4:0] op;
    logic [15:0] a;
    logic [15:0] b;
    logic coe;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(9))
        0:       op = 5'($urandom);
        1:       op = 5'b00110;
        default: op = single_ops[$urandom_range(18)];
      endcase
      a = rand_operand();
      b = rand_operand();
      coe = 1'($urandom_range(1));
      exp = model(op, a, b, coe);
      run_op(op, a, b, coe, got, ok);
      vectors++;
      if (!ok || got !== exp) begin
        miscompares++;
        $display("FAIL random[%0d] op=%b a=%h b=%h coe=%b: ok=%b {v,c,C}=%b_%h, required %b_%h",
                 i, op, a, b, coe, ok, got[17:16], got[15:0], exp[17:16], exp[15:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] expq [$];
    logic [17:0] exp;
    logic [4:0] op;
    bus16.out_ready = 1'b1;
    bus16.in_valid = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) begin
        exp = expq.pop_front();
        vectors++;
        if (bus16.out_valid !== 1'b1 || {bus16.vout, bus16.cout, bus16.C} !== exp ||
            bus16.in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL back_to_back[%0d]: ov=%b rdy=%b {v,c,C}=%b%b_%h, required ov=1 rdy=1 %b_%h",
                   i, bus16.out_valid, bus16.in_ready, bus16.vout, bus16.cout, bus16.C,
                   exp[17:16], exp[15:0]);
        end
      end
      if (i == 20) break;
      op = single_ops[$urandom_range(18)];
      bus16.alu_code = op;
      bus16.A = rand_operand();
      bus16.B = rand_operand();
      bus16.coe = 1'($urandom_range(1));
      expq.push_back(model(op, bus16.A, bus16.B, bus16.coe));
      step();
    end
    bus16.in_valid = 1'b0;
    step();
    vectors++;
    if (bus16.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL back_to_back_drain: ov=%b, required 0", bus16.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus16.out_ready = 1'b0;
    bus16.alu_code = 5'b11001;
    bus16.A = 16'hFFFF;
    bus16.B = 16'h0001;
    bus16.coe = 1'b0;
    bus16.in_valid = 1'b1;
    step();
    bus16.alu_code = 5'b00000;
    bus16.A = 16'h0005;
    bus16.B = 16'h0006;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus16.out_valid !== 1'b1 || bus16.C !== 16'h0001 || bus16.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: ov=%b C=%h rdy=%b, required ov=1 C=0001 rdy=0",
                 i, bus16.out_valid, bus16.C, bus16.in_ready);
      end
      step();
    end
    bus16.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus16.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL backpressure_release_ready: rdy=%b, required 1", bus16.in_ready);
    end
    step();
    bus16.in_valid = 1'b0;
    vectors++;
    if (bus16.out_valid !== 1'b1 || bus16.C !== 16'h000B) begin
      miscompares++;
      $display("FAIL backpressure_overwrite: ov=%b C=%h, required ov=1 C=000b", bus16.out_valid, bus16.C);
    end
    step();
  endtask

  task automatic test_mul();
    logic [15:0] as   [2] = '{16'h0100, 16'hFFFD};
    logic [15:0] bs   [2] = '{16'h0100, 16'h0004};
    bus16.out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      bus16.alu_code = 5'b00110;
      bus16.A = as[t];
      bus16.B = bs[t];
      bus16.coe = 1'b0;
      bus16.in_valid = 1'b1;
      step();
      bus16.in_valid = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      for (int k = 0; k <= 16; k++) begin
        vectors++;
        if (k < 16) begin
          if (bus16.busy !== 1'b1 || bus16.out_valid !== 1'b0 || bus16.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_busy[%0d][%0d]: busy=%b ov=%b rdy=%b, required busy=1 ov=0 rdy=0",
                     t, k, bus16.busy, bus16.out_valid, bus16.in_ready);
          end
        end else if (bus16.busy !== 1'b0 || bus16.out_valid !== 1'b1 ||
                     {bus16.vout, bus16.cout, bus16.C} !== model(5'b00110, as[t], bs[t], 1'b0)) begin
          miscompares++;
          $display("FAIL mul_done[%0d]: busy=%b ov=%b {v,c,C}=%b%b_%h, required busy=0 ov=1 %b_%h",
                   t, bus16.busy, bus16.out_valid, bus16.vout, bus16.cout, bus16.C,
                   model(5'b00110, as[t], bs[t], 1'b0) >> 16, as[t] * bs[t]);
        end
        if (k < 16) step();
      end
`else
      vectors++;
      if (bus16.busy !== 1'b0 || bus16.out_valid !== 1'b1 ||
          {bus16.vout, bus16.cout, bus16.C} !== 18'h0) begin
        miscompares++;
        $display("FAIL mul_disabled[%0d]: busy=%b ov=%b {v,c,C}=%b%b_%h, required busy=0 ov=1 00_0000",
                 t, bus16.busy, bus16.out_valid, bus16.vout, bus16.cout, bus16.C);
      end
`endif
      step();
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [17:0] got;
    logic ok;
    bus16.out_ready = 1'b1;
    bus16.alu_code = 5'b00110;
    bus16.A = 16'h1234;
    bus16.B = 16'h0567;
    bus16.coe = 1'b0;
    bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus16.busy !== 1'b0 || bus16.out_valid !== 1'b0 || bus16.C !== 16'h0 ||
        bus16.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_mul: busy=%b ov=%b C=%h rdy=%b, required busy=0 ov=0 C=0000 rdy=1",
               bus16.busy, bus16.out_valid, bus16.C, bus16.in_ready);
    end
    #2;
    rst_n = 1'b1;
    step();
    run_op(5'b10011, 16'h8000, 16'h0004, 1'b0, got, ok);
    vectors++;
    if (!ok || got !== {2'b00, 16'hF800}) begin
      miscompares++;
      $display("FAIL post_reset_sra: ok=%b {v,c,C}=%b_%h, required 00_f800", ok, got[17:16], got[15:0]);
    end
  endtask

  task automatic test_wide();
    logic [4:0]  ops [2] = '{5'b10000, 5'b10011};
    logic [31:0] as  [2] = '{32'h0000_0001, 32'h8000_0000};
    logic [31:0] bs  [2] = '{32'h0000_0025, 32'h0000_003F};
    logic [31:0] exs [2] = '{32'h0000_0020, 32'hFFFF_FFFF};
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus32.alu_code = ops[i];
      bus32.A = as[i];
      bus32.B = bs[i];
      bus32.coe = 1'b0;
      bus32.in_valid = 1'b1;
      step();
      bus32.in_valid = 1'b0;
      vectors++;
      if (bus32.out_valid !== 1'b1 || bus32.C !== exs[i]) begin
        miscompares++;
        $display("FAIL wide32[%0d]: ov=%b C=%h, required ov=1 C=%h", i, bus32.out_valid, bus32.C, exs[i]);
      end
      step();
    end
  endtask

  initial begin
    bus16.in_valid  = 1'b0;
    bus16.A         = '0;
    bus16.B         = '0;
    bus16.alu_code  = '0;
    bus16.coe       = 1'b0;
    bus16.out_ready = 1'b1;
    bus32.in_valid  = 1'b0;
    bus32.A         = '0;
    bus32.B         = '0;
    bus32.alu_code  = '0;
    bus32.coe       = 1'b0;
    bus32.out_ready = 1'b1;
    test_reset();
    test_flags();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_mul();
    test_reset_mid_mul();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
